// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: valid/ready load, MSB-first output with a bit strobe, frame_start and done.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] din,
    input  logic             shift_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             done
);
`ifdef PISO_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CW = $clog2(FRAME_LEN + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] shreg_reg, shreg_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             sout_reg, sout_next;
    logic             valid_reg, valid_next;
    logic             start_reg, start_next;
    logic             done_reg, done_next;
    logic             bit_out;
`ifdef PISO_PARITY_EN
    logic             parity_reg, parity_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            shreg_reg  <= '0;
            cnt_reg    <= '0;
            sout_reg   <= 1'b0;
            valid_reg  <= 1'b0;
            start_reg  <= 1'b0;
            done_reg   <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            shreg_reg  <= shreg_next;
            cnt_reg    <= cnt_next;
            sout_reg   <= sout_next;
            valid_reg  <= valid_next;
            start_reg  <= start_next;
            done_reg   <= done_next;
`ifdef PISO_PARITY_EN
            parity_reg <= parity_next;
`endif
        end
    end

    // Once all data bits have left, the shift register is empty and the parity bit goes out instead.
`ifdef PISO_PARITY_EN
    assign bit_out = (cnt_reg == CW'(WIDTH)) ? parity_reg : shreg_reg[WIDTH-1];
`else
    assign bit_out = shreg_reg[WIDTH-1];
`endif

    always_comb begin
        state_next  = state_reg;
        shreg_next  = shreg_reg;
        cnt_next    = cnt_reg;
        sout_next   = 1'b0;
        valid_next  = 1'b0;
        start_next  = 1'b0;
        done_next   = 1'b0;
`ifdef PISO_PARITY_EN
        parity_next = parity_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (load_valid) begin
                    shreg_next  = din;
                    cnt_next    = '0;
                    state_next  = SHIFT;
`ifdef PISO_PARITY_EN
                    parity_next = ^din;
`endif
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    sout_next  = bit_out;
                    valid_next = 1'b1;
                    shreg_next = {shreg_reg[WIDTH-2:0], 1'b0};
                    cnt_next   = cnt_reg + CW'(1);
                    start_next = (cnt_reg == '0);
                    done_next  = (cnt_reg == CW'(FRAME_LEN - 1));
                    if (cnt_reg == CW'(FRAME_LEN - 1)) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign load_ready  = (state_reg == IDLE);
    assign sout        = sout_reg;
    assign sout_valid  = valid_reg;
    assign frame_start = start_reg;
    assign done        = done_reg;
endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: expected bits are queued at load time and popped as the DUT emits them.
module tb_piso_serializer;
    localparam int WIDTH = 8;
`ifdef PISO_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    typedef struct packed {
        logic b;
        logic fs;
        logic dn;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             load_valid = 1'b0;
    logic             load_ready;
    logic [WIDTH-1:0] din = '0;
    logic             shift_en = 1'b0;
    logic             sout, sout_valid, frame_start, done;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   frames_done = 0;

    piso_serializer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
        .din(din), .shift_en(shift_en), .sout(sout), .sout_valid(sout_valid),
        .frame_start(frame_start), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Monitor: sample 1 time unit after each rising edge.
    always begin
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (sout_valid) begin
                if (sb.size() == 0) begin
                    check("extra_bit", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sout", sout, e.b);
                    check("frame_start", frame_start, e.fs);
                    check("done", done, e.dn);
                    check("ready_vs_done", load_ready, e.dn);
                    if (e.dn) frames_done++;
                end
            end else begin
                check("idle_out", {sout, frame_start, done}, 3'b000);
            end
        end
    end

    task automatic push_frame(input logic [WIDTH-1:0] w);
        exp_t e;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            e.b  = w[i];
            e.fs = (i == WIDTH - 1);
            e.dn = (i == 0) && !PAR;
            sb.push_back(e);
        end
        if (PAR) begin
            e.b  = ^w;
            e.fs = 1'b0;
            e.dn = 1'b1;
            sb.push_back(e);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, {sout, sout_valid, frame_start, done, load_ready}, 5'b00001);
    endtask

    // alt: shift_en toggles 1/0; intrude: pulse a load after that many bits; abort_n: reset after that many bits.
    task automatic send(input logic [WIDTH-1:0] w, input bit alt, input int intrude, input int abort_n);
        int en_edges;
        int start;
        bit aborted;
        en_edges = 0;
        aborted  = 1'b0;
        @(negedge clk);
        check("ready_before_load", load_ready, 1);
        load_valid = 1'b1;
        din        = w;
        shift_en   = 1'b1;
        push_frame(w);
        start = frames_done;
        for (int c = 0; c < 60 && frames_done == start && !aborted; c++) begin
            @(negedge clk);
            load_valid = 1'b0;
            din        = WIDTH'($urandom);
            if (abort_n > 0 && en_edges == abort_n) begin
                rst_n = 1'b0;
                sb.delete();
                #1;
                check_reset_outputs("abort_reset");
                @(negedge clk);
                check_reset_outputs("abort_hold");
                rst_n   = 1'b1;
                aborted = 1'b1;
            end else begin
                if (intrude > 0 && en_edges == intrude) begin
                    load_valid = 1'b1;
                    din        = '1;
                    check("ready_busy", load_ready, 0);
                end
                shift_en = alt ? (c % 2 == 0) : 1'b1;
                if (shift_en) en_edges++;
            end
        end
        if (!aborted) begin
            check("frame_timeout", (frames_done == start + 1) ? 32'd1 : 32'd0, 32'd1);
            check("ready_after", load_ready, 1);
        end
        shift_en   = 1'b0;
        load_valid = 1'b0;
    endtask

    initial begin
        #3;
        check_reset_outputs("reset_state");
        @(negedge clk);
        check_reset_outputs("reset_held");
        rst_n = 1'b1;
        @(negedge clk);
        shift_en = 1'b1;
        @(negedge clk);
        check("idle_ignores_en", sout_valid, 0);
        shift_en = 1'b0;

        send(8'hA5, 1'b0, 0, 0);
        send(8'h3C, 1'b1, 0, 0);
        send(8'hA5, 1'b0, 3, 0);
        send(8'hF0, 1'b0, 0, 3);
        send(8'h81, 1'b0, 0, 0);
        send(8'h07, 1'b0, 0, 0);
        send(8'h03, 1'b1, 0, 0);
        for (int k = 0; k < 3; k++) send(WIDTH'($urandom), k[0], 0, 0);

        repeat (4) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter.
- Accepts a WIDTH-bit word through a valid/ready load handshake and emits it MSB-first, one bit per enabled clock.
- Each emitted bit is qualified by a strobe, so a downstream serial-in shift chain can capture it directly.
- Sits at the transmit end of the team's serial bit links.

Parameters:
- WIDTH, 8, data word width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- load_valid  input  1  din holds a word to transmit.
- load_ready  output  1  serializer can accept a word this cycle.
- din  input  WIDTH  parallel word; sampled only on an accepted load.
- shift_en  input  1  bit-rate enable; one bit is emitted per clock with shift_en=1 while shifting.
- sout  output  1  serial data, MSB first; 0 whenever sout_valid=0.
- sout_valid  output  1  sout carries a frame bit this cycle.
- frame_start  output  1  high with the first bit of a frame.
- done  output  1  one-cycle pulse with the last bit of a frame.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - state=IDLE, shift register=0, bit counter=0, stored parity=0.
  - sout=0, sout_valid=0, frame_start=0, done=0, load_ready=1.
- Outputs:
  - All outputs are registered.
  - load_ready = (state==IDLE), decoded from the state register.
- States: IDLE, SHIFT.
- IDLE:
  - load_ready=1.
  - On an edge with load_valid=1: shreg<=din, cnt<=0, state->SHIFT. load_ready falls after that edge.
  - shift_en is ignored in IDLE.
- SHIFT, edge with shift_en=1:
  - sout<=shreg[WIDTH-1], sout_valid<=1.
  - shreg shifts left with 0 fill; cnt<=cnt+1.
  - frame_start<=(cnt==0).
  - done<=(cnt==FRAME_LEN-1).
  - On the last bit: state->IDLE.
- SHIFT, edge with shift_en=0:
  - sout<=0, sout_valid<=0, frame_start<=0, done<=0.
  - Shift register and counter hold.
- Counter:
  - Width $clog2(FRAME_LEN+1), so it never wraps within a frame.
  - FRAME_LEN = WIDTH, or WIDTH+1 with the optional feature.
- Latency and throughput:
  - Load accepted at edge N. First bit is visible after edge N+1 if shift_en=1 at N+1; otherwise at the first later edge with shift_en=1.
  - Back-to-back words: the earliest next load is at the edge after the last bit, giving a minimum one-cycle gap with sout_valid=0 between frames.
- Boundary conditions:
  - load_valid while in SHIFT: ignored (load_ready=0); the word in flight is unaffected.
  - Changes on din outside an accepted load: no effect.
  - frame_start and done are both high only if FRAME_LEN==1, which is impossible since WIDTH>=2.
  - Reset mid-frame: everything immediately returns to reset values and the partial frame is discarded. No done pulse is emitted for the aborted frame.
  - After reset release, the first load behaves exactly as after power-up.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - On an accepted load, even parity (XOR of all din bits) is captured.
  - FRAME_LEN = WIDTH+1. After the WIDTH data bits, one extra enabled shift emits the parity bit with sout_valid=1.
  - done pulses with the parity bit, not the last data bit.
- Undefined:
  - No parity logic or register; FRAME_LEN = WIDTH; done pulses with data bit 0.

Test Plan:
- Reset: rst_n=0 at any point, including mid-frame -> sout=0, sout_valid=0, frame_start=0, done=0, load_ready=1 asynchronously; state IDLE.
- WIDTH=8, load din=8'hA5, shift_en held 1 -> 8 consecutive valid bits 1,0,1,0,0,1,0,1; frame_start on bit 1; done on bit 8; load_ready=1 the cycle after; sout=0 otherwise.
- Load 8'h3C with shift_en alternating 1/0 -> bits 0,0,1,1,1,1,0,0 spread over 16 cycles; sout_valid=0 and sout=0 on every disabled cycle; done on the 8th valid bit.
- During the 8'hA5 frame, pulse load_valid with din=8'hFF at bit 4 -> load ignored, load_ready stays 0, output sequence unchanged, no extra frame.
- Load 8'hF0, assert rst_n low after 3 bits, release, load 8'h81 -> aborted frame with no done; new frame emits 1,0,0,0,0,0,0,1 with frame_start on the first bit.
- PISO_PARITY_EN defined: 8'h07 -> 9 bits, 9th = 1, done on the 9th; 8'h03 -> 9th bit = 0. Macro undefined: same loads give 8-bit frames, done on the 8th.
